// File: rtl/seg7_pkg.sv
// Shared segment patterns (active-low, {a,b,c,d,e,f,g}) and scan state type
// for the seven-segment scan driver.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b0000001;
    localparam logic [6:0] SEG_1    = 7'b1001111;
    localparam logic [6:0] SEG_2    = 7'b0010010;
    localparam logic [6:0] SEG_3    = 7'b0000110;
    localparam logic [6:0] SEG_4    = 7'b1001100;
    localparam logic [6:0] SEG_5    = 7'b0100100;
    localparam logic [6:0] SEG_6    = 7'b0100000;
    localparam logic [6:0] SEG_7    = 7'b0001111;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0000100;
    localparam logic [6:0] SEG_A    = 7'b0001000;
    localparam logic [6:0] SEG_B    = 7'b1100000;
    localparam logic [6:0] SEG_C    = 7'b0110001;
    localparam logic [6:0] SEG_D    = 7'b1000010;
    localparam logic [6:0] SEG_E    = 7'b0110000;
    localparam logic [6:0] SEG_F    = 7'b0111000;
    localparam logic [6:0] SEG_DASH = 7'b1111110;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg7_nibble_dec.sv
// Combinational nibble to active-low seven-segment decoder.
// HEX_MODE=1 shows 10..15 as A b C d E F, otherwise as a dash.
module seg7_nibble_dec
    import seg7_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        // NOTE: assign every always_comb output a default first so no path can infer a latch.
        seg_o = SEG_DASH;
        case (nib_i)
            4'd0:  seg_o = SEG_0;
            4'd1:  seg_o = SEG_1;
            4'd2:  seg_o = SEG_2;
            4'd3:  seg_o = SEG_3;
            4'd4:  seg_o = SEG_4;
            4'd5:  seg_o = SEG_5;
            4'd6:  seg_o = SEG_6;
            4'd7:  seg_o = SEG_7;
            4'd8:  seg_o = SEG_8;
            4'd9:  seg_o = SEG_9;
            4'd10: seg_o = (HEX_MODE != 0) ? SEG_A : SEG_DASH;
            4'd11: seg_o = (HEX_MODE != 0) ? SEG_B : SEG_DASH;
            4'd12: seg_o = (HEX_MODE != 0) ? SEG_C : SEG_DASH;
            4'd13: seg_o = (HEX_MODE != 0) ? SEG_D : SEG_DASH;
            4'd14: seg_o = (HEX_MODE != 0) ? SEG_E : SEG_DASH;
            4'd15: seg_o = (HEX_MODE != 0) ? SEG_F : SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with dead-time between digits.
// Define SEG7_LZB_EN to blank leading zeros (digit 0 is always shown).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16,
    parameter int HEX_MODE    = 0
) (
    input  logic                clk,
    input  logic                resett,
    input  logic                load,
    input  logic [4*DIGITS-1:0] data,
    output logic                load_ack,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an
);

    localparam int CNT_MAX = max2(REFRESH_DIV, BLANK_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [4*DIGITS-1:0] shadow_q;
    logic                ack_q;

    logic [3:0]          nib_sel;
    logic [6:0]          dec_seg;
    logic                lzb_blank;

    always_comb begin
        nib_sel = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) nib_sel = shadow_q[4*i +: 4];
        end
    end

`ifdef SEG7_LZB_EN
    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        lzb_blank = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) lzb_blank = ((shadow_q >> (4*i)) == '0);
        end
    end
`else
    assign lzb_blank = 1'b0;
`endif

    seg7_nibble_dec #(
        .HEX_MODE (HEX_MODE)
    ) u_dec (
        .nib_i (nib_sel),
        .seg_o (dec_seg)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        seg_d   = seg_q;
        an_d    = an_q;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    seg_d   = lzb_blank ? SEG_OFF : dec_seg;
                    for (int i = 0; i < DIGITS; i++) an_d[i] = (idx_q != IDX_W'(i));
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    seg_d   = SEG_OFF;
                    an_d    = '1;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (resett) begin
            state_q  <= ST_BLANK;
            cnt_q    <= '0;
            idx_q    <= '0;
            seg_q    <= SEG_OFF;
            an_q     <= '1;
            ack_q    <= 1'b0;
            // NOTE: the shadow word is reset too, so a fresh display reads 0 rather than garbage.
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            ack_q    <= load;
            if (load) shadow_q <= data;
        end
    end

    assign load_ack = ack_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: two DUTs (decimal and hex decode) against a timeline model
// that derives each digit slot from the cycle count since reset release.
module tb_seg7_scan_driver;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;
    localparam int BLANK_CYC   = 2;
    localparam int PERIOD      = REFRESH_DIV + BLANK_CYC;
`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resett, load;
    logic [15:0] data;
    logic        ack_d, ack_h;
    logic [6:0]  seg_d, seg_h;
    logic [3:0]  an_d, an_h;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS (DIGITS), .REFRESH_DIV (REFRESH_DIV), .BLANK_CYC (BLANK_CYC), .HEX_MODE (0)
    ) u_dut_dec (
        .clk (clk), .resett (resett), .load (load), .data (data),
        .load_ack (ack_d), .seg (seg_d), .an (an_d)
    );

    seg7_scan_driver #(
        .DIGITS (DIGITS), .REFRESH_DIV (REFRESH_DIV), .BLANK_CYC (BLANK_CYC), .HEX_MODE (1)
    ) u_dut_hex (
        .clk (clk), .resett (resett), .load (load), .data (data),
        .load_ack (ack_h), .seg (seg_h), .an (an_h)
    );

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg_dec;
        logic [6:0] seg_hex;
    } ev_t;

    ev_t evq_dec[$];
    ev_t evq_hex[$];
    int  ackq_dec[$];
    int  ackq_hex[$];

    int  n_cmp   = 0;
    int  n_err   = 0;
    bit  started = 1'b0;
    int  cyc     = 0;
    int  e       = 0;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [6:0] ref_seg(input int nib, input bit hex);
        if (nib < 10 || hex) return seg_tab[nib];
        return 7'b1111110;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: slot position is plain arithmetic on edges since reset release.
    int         m_t = 0;
    logic [15:0] m_shadow = '0;
    int         m_idx = 0;
    int         m_nib = 0;
    bit         m_zero = 1'b0;
    logic [3:0] p_an = 4'hF;
    logic [6:0] p_sd = 7'h7F;
    logic [6:0] p_sh = 7'h7F;

    always @(posedge clk) begin
        logic [3:0] an_e;
        logic [6:0] sd, sh;
        int u;
        ev_t ev;
        cyc++;
        an_e = 4'hF;
        sd   = 7'h7F;
        sh   = 7'h7F;
        if (resett) begin
            m_t      = 0;
            m_shadow = '0;
        end else begin
            m_t++;
            u = m_t - BLANK_CYC;
            if (u >= 0) begin
                if (u % PERIOD == 0) begin
                    m_idx  = (u / PERIOD) % DIGITS;
                    m_nib  = int'((m_shadow >> (4*m_idx)) & 16'hF);
                    m_zero = (m_idx > 0) && ((m_shadow >> (4*m_idx)) == 16'h0);
                end
                if (u % PERIOD < REFRESH_DIV) begin
                    an_e = ~(4'b0001 << m_idx);
                    sd   = ref_seg(m_nib, 1'b0);
                    sh   = ref_seg(m_nib, 1'b1);
                    if (LZB && m_zero) begin
                        sd = 7'h7F;
                        sh = 7'h7F;
                    end
                end
            end
            if (load) begin
                m_shadow = data;
                if (started) begin
                    ackq_dec.push_back(cyc);
                    ackq_hex.push_back(cyc);
                end
            end
        end
        if (started && ({an_e, sd, sh} != {p_an, p_sd, p_sh})) begin
            ev.cyc = cyc; ev.an = an_e; ev.seg_dec = sd; ev.seg_hex = sh;
            evq_dec.push_back(ev);
            evq_hex.push_back(ev);
        end
        p_an = an_e;
        p_sd = sd;
        p_sh = sh;
    end

    // Monitor: every change of {an,seg} and every ack cycle consumes one expectation.
    logic [10:0] last_dec = 11'h7FF;
    logic [10:0] last_hex = 11'h7FF;

    always @(negedge clk) begin
        ev_t ev;
        int  c;
        if (started) begin
            if ({an_d, seg_d} !== last_dec) begin
                last_dec = {an_d, seg_d};
                check("dec_evt_pending", 32'(evq_dec.size() != 0), 32'd1);
                if (evq_dec.size() != 0) begin
                    ev = evq_dec.pop_front();
                    check("dec_evt_cycle", cyc, ev.cyc);
                    check("dec_an", 32'(an_d), 32'(ev.an));
                    check("dec_seg", 32'(seg_d), 32'(ev.seg_dec));
                end
            end
            if ({an_h, seg_h} !== last_hex) begin
                last_hex = {an_h, seg_h};
                check("hex_evt_pending", 32'(evq_hex.size() != 0), 32'd1);
                if (evq_hex.size() != 0) begin
                    ev = evq_hex.pop_front();
                    check("hex_evt_cycle", cyc, ev.cyc);
                    check("hex_an", 32'(an_h), 32'(ev.an));
                    check("hex_seg", 32'(seg_h), 32'(ev.seg_hex));
                end
            end
            if (ack_d !== 1'b0) begin
                check("dec_ack_pending", 32'(ackq_dec.size() != 0), 32'd1);
                if (ackq_dec.size() != 0) begin
                    c = ackq_dec.pop_front();
                    check("dec_ack_cycle", cyc, c);
                end
            end
            if (ack_h !== 1'b0) begin
                check("hex_ack_pending", 32'(ackq_hex.size() != 0), 32'd1);
                if (ackq_hex.size() != 0) begin
                    c = ackq_hex.pop_front();
                    check("hex_ack_cycle", cyc, c);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        e++;
    endtask

    task automatic run_to(input int t);
        while (e < t) tick();
    endtask

    // Load is sampled on edge e+1.
    task automatic load_word(input logic [15:0] d);
        load = 1'b1;
        data = d;
        tick();
        load = 1'b0;
        data = 16'($urandom);
    endtask

    initial begin
        int t2;
        resett = 1'b1;
        load   = 1'b0;
        data   = '0;
        @(negedge clk);
        started = 1'b1;
        check("rst_an_dec", 32'(an_d), 32'hF);
        check("rst_seg_dec", 32'(seg_d), 32'h7F);
        check("rst_ack_dec", 32'(ack_d), 32'h0);
        check("rst_an_hex", 32'(an_h), 32'hF);
        @(negedge clk);
        resett = 1'b0;
        e = 0;

        load_word(16'h1234);
        check("t1_blank_an", 32'(an_d), 32'hF);
        run_to(2);
        check("t2_digit0_an", 32'(an_d), 32'b1110);
        check("t2_digit0_seg", 32'(seg_d), 32'b1001100);
        run_to(8);
        check("t8_digit1_an", 32'(an_d), 32'b1101);
        check("t8_digit1_seg", 32'(seg_d), 32'b0000110);

        run_to(44);
        load_word(16'h0009);
        run_to(51);
        load_word(16'h0008);
        run_to(53);
        check("midshow_hold", 32'(seg_d), 32'b0000100);
        run_to(74);
        check("next_visit_new", 32'(seg_d), 32'b0000000);

        run_to(89);
        load_word(16'h0001);
        run_to(97);
        load_word(16'h0002);
        check("same_edge_old", 32'(seg_d), 32'b1001111);

        run_to(123);
        load_word(16'hABCF);
        run_to(146);
        check("hexF_hex", 32'(seg_h), 32'b0111000);
        check("hexF_dec", 32'(seg_d), 32'b1111110);
        run_to(164);
        check("hexA_hex", 32'(seg_h), 32'b0001000);

        run_to(168);
        load_word(16'h0050);
        run_to(188);
        check("lead_zero_idx3", 32'(seg_d), LZB ? 32'h7F : 32'b0000001);

        run_to(200);
        load_word(16'h1111);
        load_word(16'h2222);
        load_word(16'h3333);

        repeat (300) begin
            load = ($urandom_range(0, 7) == 0);
            data = 16'($urandom);
            tick();
        end
        load = 1'b0;

        t2 = 14;
        while (t2 <= e) t2 += DIGITS * PERIOD;
        run_to(t2 + 1);
        resett = 1'b1;
        @(negedge clk);
        check("midreset_an", 32'(an_d), 32'hF);
        check("midreset_seg", 32'(seg_d), 32'h7F);
        @(negedge clk);
        resett = 1'b0;
        e = 0;
        run_to(1);
        check("post_rst_blank", 32'(an_d), 32'hF);
        run_to(2);
        check("post_rst_an", 32'(an_d), 32'b1110);
        check("post_rst_zero", 32'(seg_d), 32'b0000001);
        run_to(40);

        check("dec_evt_leftover", evq_dec.size(), 0);
        check("hex_evt_leftover", evq_hex.size(), 0);
        check("dec_ack_leftover", ackq_dec.size(), 0);
        check("hex_ack_leftover", ackq_hex.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
